// File: rtl/multiplicador_secuencial.sv
// Iterative shift-add N x N multiplier, one multiplier bit per clock.
// Supports unsigned and two's-complement signed operands via a start/done handshake.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               request, accepted in IDLE or DONE
//   signed_mode         0 = unsigned, 1 = signed; latched with start
//   aIn, bIn            multiplicand / multiplier; latched with start
//   busy, done          status (busy while iterating, done while result valid)
//   cOut                low N bits of the product
//   product             full 2N-bit product
//   CFlag, OFlag, ZFlag carry (unsigned only), overflow past N bits, zero
module multiplicador_secuencial #(
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [N-1:0]     aIn,
    input  logic [N-1:0]     bIn,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     cOut,
    output logic [2*N-1:0]   product,
    output logic             CFlag,
    output logic             OFlag,
    output logic             ZFlag
);

    localparam int unsigned W2 = 2 * N;
    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_n;
    logic            mode_q, mode_n;
    logic            neg_q, neg_n;
    logic [N-1:0]    a_q, a_n;
    logic [N-1:0]    b_q, b_n;
    logic [W2-1:0]   acc_q, acc_n;
    logic [CW-1:0]   cnt_q, cnt_n;

    logic            busy_n, done_n;
    logic [N-1:0]    cout_n;
    logic [W2-1:0]   product_n;
    logic            cflag_n, oflag_n, zflag_n;

    logic [W2-1:0]   addend;
    logic [W2-1:0]   acc_sum;
    logic [W2-1:0]   prod;
    logic [N:0]      upper;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            neg_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cOut    <= '0;
            product <= '0;
            CFlag   <= 1'b0;
            OFlag   <= 1'b0;
            ZFlag   <= 1'b0;
        end else begin
            state_q <= state_n;
            mode_q  <= mode_n;
            neg_q   <= neg_n;
            a_q     <= a_n;
            b_q     <= b_n;
            acc_q   <= acc_n;
            cnt_q   <= cnt_n;
            busy    <= busy_n;
            done    <= done_n;
            cOut    <= cout_n;
            product <= product_n;
            CFlag   <= cflag_n;
            OFlag   <= oflag_n;
            ZFlag   <= zflag_n;
        end
    end

    // Next-state, iteration and result logic
    always_comb begin
        state_n   = state_q;
        mode_n    = mode_q;
        neg_n     = neg_q;
        a_n       = a_q;
        b_n       = b_q;
        acc_n     = acc_q;
        cnt_n     = cnt_q;
        busy_n    = busy;
        done_n    = done;
        cout_n    = cOut;
        product_n = product;
        cflag_n   = CFlag;
        oflag_n   = OFlag;
        zflag_n   = ZFlag;

        // One partial product per cycle: multiplicand shifted by the bit index
        addend  = b_q[cnt_q] ? (W2'(a_q) << cnt_q) : '0;
        acc_sum = acc_q + addend;
        prod    = neg_q ? -acc_sum : acc_sum;
        upper   = prod[W2-1:N-1];

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_n = BUSY;
                    mode_n  = signed_mode;
                    // Magnitude of the most negative value still fits N unsigned bits
                    a_n     = (signed_mode && aIn[N-1]) ? -aIn : aIn;
                    b_n     = (signed_mode && bIn[N-1]) ? -bIn : bIn;
                    neg_n   = signed_mode & (aIn[N-1] ^ bIn[N-1]);
                    acc_n   = '0;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                end
            end
            BUSY: begin
                acc_n = acc_sum;
                cnt_n = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_n   = DONE;
                    busy_n    = 1'b0;
                    done_n    = 1'b1;
                    product_n = prod;
                    cout_n    = prod[N-1:0];
                    cflag_n   = mode_q ? 1'b0 : prod[N];
                    // Signed result fits when the top N+1 bits are a pure sign extension
                    oflag_n   = mode_q ? ((|upper) && !(&upper)) : (|prod[W2-1:N]);
                    zflag_n   = (prod == '0);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Directed self-checking bench for multiplicador_secuencial (N = 4).
module tb_multiplicador_secuencial;

    localparam int unsigned N = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic           signed_mode;
    logic [N-1:0]   aIn;
    logic [N-1:0]   bIn;
    logic           busy;
    logic           done;
    logic [N-1:0]   cOut;
    logic [2*N-1:0] product;
    logic           CFlag;
    logic           OFlag;
    logic           ZFlag;

    int n_cmp = 0;
    int n_err = 0;
    logic [2*N-1:0] last_p = '0;

    multiplicador_secuencial #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .aIn(aIn), .bIn(bIn), .busy(busy), .done(done), .cOut(cOut),
        .product(product), .CFlag(CFlag), .OFlag(OFlag), .ZFlag(ZFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 8'(busy), 8'h00);
        check({tag, "_done"}, 8'(done), 8'h00);
        check({tag, "_prod"}, product, 8'h00);
        check({tag, "_cout"}, 8'(cOut), 8'h00);
        check({tag, "_flags"}, {5'b0, CFlag, OFlag, ZFlag}, 8'h00);
    endtask

    // Launch one multiply and check latency, hold-during-busy and the final result
    task automatic run_op(input string tag, input logic sm, input logic [3:0] a,
                          input logic [3:0] b, input logic disturb,
                          input logic [7:0] ep, input logic [3:0] ec,
                          input logic c, input logic o, input logic z);
        @(negedge clk);
        start = 1'b1; signed_mode = sm; aIn = a; bIn = b;
        @(posedge clk);
        #1;
        start = 1'b0; signed_mode = ~sm; aIn = 4'($urandom); bIn = 4'($urandom);
        check({tag, "_busy_on"}, 8'(busy), 8'h01);
        check({tag, "_done_off"}, 8'(done), 8'h00);
        check({tag, "_hold"}, product, last_p);
        for (int i = 1; i <= int'(N); i++) begin
            if (disturb && i == 1) begin
                @(negedge clk);
                start = 1'b1; aIn = 4'h7; bIn = 4'h7; signed_mode = 1'b0;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (i == int'(N) - 1) begin
                check({tag, "_done_early"}, 8'(done), 8'h00);
                check({tag, "_busy_mid"}, 8'(busy), 8'h01);
            end
        end
        check({tag, "_done"}, 8'(done), 8'h01);
        check({tag, "_busy_off"}, 8'(busy), 8'h00);
        check({tag, "_prod"}, product, ep);
        check({tag, "_cout"}, 8'(cOut), 8'(ec));
        check({tag, "_C"}, 8'(CFlag), 8'(c));
        check({tag, "_O"}, 8'(OFlag), 8'(o));
        check({tag, "_Z"}, 8'(ZFlag), 8'(z));
        last_p = ep;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; aIn = '0; bIn = '0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("idle");

        // Unsigned products
        run_op("u3x5",   1'b0, 4'd3,  4'd5,  1'b0, 8'h0F, 4'hF, 1'b0, 1'b0, 1'b0);
        run_op("u6x3",   1'b0, 4'd6,  4'd3,  1'b0, 8'h12, 4'h2, 1'b1, 1'b1, 1'b0);
        run_op("u15x15", 1'b0, 4'd15, 4'd15, 1'b0, 8'hE1, 4'h1, 1'b0, 1'b1, 1'b0);

        // Signed products
        run_op("s-2x3",  1'b1, 4'hE,  4'd3,  1'b0, 8'hFA, 4'hA, 1'b0, 1'b0, 1'b0);
        run_op("s-3x5",  1'b1, 4'hD,  4'd5,  1'b0, 8'hF1, 4'h1, 1'b0, 1'b1, 1'b0);
        run_op("s-8x-8", 1'b1, 4'h8,  4'h8,  1'b0, 8'h40, 4'h0, 1'b0, 1'b1, 1'b0);

        // Zero results in both modes
        run_op("u0x9",   1'b0, 4'd0,  4'd9,  1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1);
        run_op("s0x9",   1'b1, 4'd0,  4'h9,  1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1);

        // Result holds in DONE while start stays low
        run_op("u7x2",   1'b0, 4'd7,  4'd2,  1'b0, 8'h0E, 4'hE, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_done", 8'(done), 8'h01);
        check("hold_prod", product, 8'h0E);

        // Start pulse during BUSY must be ignored
        run_op("ign3x5", 1'b0, 4'd3,  4'd5,  1'b1, 8'h0F, 4'hF, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b0; aIn = 4'd15; bIn = 4'd15;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_zero("after_rst");
        last_p = '0;
        run_op("s-3x-3", 1'b1, 4'hD,  4'hD,  1'b0, 8'h09, 4'h9, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
